// File: rtl/bus_slave_if.sv
// Bus responder front end: accepts a strobed access when selected, inserts wait
// states, runs a req/ack handshake to the local device and returns a one-cycle rdy_.
module bus_slave_if #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_cs_,
  input  logic              bus_as_,
  input  logic              bus_rw,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wr_data,
  output logic [DATA_W-1:0] bus_rd_data,
  output logic              bus_rdy_,
  output logic              dev_req,
  output logic              dev_rw,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_wr_data,
  input  logic [DATA_W-1:0] dev_rd_data,
  input  logic              dev_ack,
  input  logic              err_clr,
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_RDY  = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [TO_W-1:0] to_cnt;

  assign state_dbg = state;

  // Handshakes: the bus side is a one-cycle as_ strobe answered by a one-cycle
  // rdy_ pulse; the device side holds dev_req and dev_* stable until dev_ack=1 is
  // sampled on a clock edge, and dev_req drops on the edge after that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      bus_rdy_    <= 1'b1;
      bus_rd_data <= '0;
      dev_req     <= 1'b0;
      dev_rw      <= 1'b1;
      dev_addr    <= '0;
      dev_wr_data <= '0;
      err         <= 1'b0;
      wait_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      // A timeout in the same cycle overrides this clear further down.
      if (err_clr) err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus_as_ && !bus_cs_) begin
            dev_addr    <= bus_addr;
            dev_rw      <= bus_rw;
            dev_wr_data <= bus_wr_data;
            if (WAIT_CYCLES == 0) begin
              dev_req <= 1'b1;
              state   <= S_REQ;
            end else begin
              wait_cnt <= 4'(WAIT_CYCLES);
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            dev_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (dev_ack) begin
            bus_rd_data <= dev_rw ? dev_rd_data : '0;
            dev_req     <= 1'b0;
            bus_rdy_    <= 1'b0;
            to_cnt      <= '0;
            state       <= S_RDY;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            bus_rd_data <= '0;
            err         <= 1'b1;
            dev_req     <= 1'b0;
            bus_rdy_    <= 1'b0;
            to_cnt      <= '0;
            state       <= S_RDY;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RDY: begin
          bus_rdy_    <= 1'b1;
          bus_rd_data <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_if.sv
// Bench for bus_slave_if: two responders (no wait / 8-cycle timeout, and 3 wait
// states / timeout disabled) on one bus, checked against a transaction-level model.
module tb_bus_slave_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cs_;
  logic        as_;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [1:0]  ack;
  logic [31:0] drd0, drd1;
  logic        err_clr;

  logic [31:0] brd0, brd1;
  logic [1:0]  rdy_, req, drw, errv;
  logic [29:0] daddr0, daddr1;
  logic [31:0] dwd0, dwd1;
  logic [1:0]  st0, st1;

  int n_checks = 0;
  int n_fail = 0;
  bit [1:0] exp_err = 2'b00;
  bit clr_hold = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bus_slave_if #(.ADDR_W(30), .DATA_W(32), .WAIT_CYCLES(0), .TIMEOUT(8)) dut0 (
    .clk(clk), .rst(rst), .bus_cs_(cs_[0]), .bus_as_(as_), .bus_rw(rw),
    .bus_addr(addr), .bus_wr_data(wdata), .bus_rd_data(brd0), .bus_rdy_(rdy_[0]),
    .dev_req(req[0]), .dev_rw(drw[0]), .dev_addr(daddr0), .dev_wr_data(dwd0),
    .dev_rd_data(drd0), .dev_ack(ack[0]), .err_clr(err_clr), .err(errv[0]),
    .state_dbg(st0)
  );

  bus_slave_if #(.ADDR_W(30), .DATA_W(32), .WAIT_CYCLES(3), .TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .bus_cs_(cs_[1]), .bus_as_(as_), .bus_rw(rw),
    .bus_addr(addr), .bus_wr_data(wdata), .bus_rd_data(brd1), .bus_rdy_(rdy_[1]),
    .dev_req(req[1]), .dev_rw(drw[1]), .dev_addr(daddr1), .dev_wr_data(dwd1),
    .dev_rd_data(drd1), .dev_ack(ack[1]), .err_clr(err_clr), .err(errv[1]),
    .state_dbg(st1)
  );

  // One access on responder sel. d = cycles of ack delay after the first request
  // cycle (negative = never ack); ks = cycle in which a stray second strobe is sent.
  task automatic access(input int sel, input logic r, input logic [29:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int d, input int ks);
    int w, to, n_req, k_rdy, o;
    bit tmo, exp_req;
    logic [31:0] exp_rd;
    w = (sel == 1) ? 3 : 0;
    to = (sel == 1) ? 0 : 8;
    o = 1 - sel;
    tmo = (to != 0) && (d < 0 || d >= to);
    n_req = tmo ? to : d + 1;
    k_rdy = w + 1 + n_req;
    exp_q.push_back((r && !tmo) ? rd : 32'h0);
    @(posedge clk); #1;
    as_ = 1'b0; cs_ = (sel == 1) ? 2'b01 : 2'b10;
    rw = r; addr = a; wdata = wd; ack = 2'b00; err_clr = clr_hold;
    @(negedge clk);
    n_checks++;
    if (rdy_[sel] !== 1'b1 || req[sel] !== 1'b0 || (sel == 1 ? brd1 : brd0) !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_before_access sel=%0d rdy_=%b req=%b rd=%h exp 1/0/0", sel, rdy_[sel], req[sel], sel == 1 ? brd1 : brd0);
    end
    for (int k = 1; k <= k_rdy; k++) begin
      @(posedge clk); #1;
      as_ = (k == ks) ? 1'b0 : 1'b1;
      addr = (k == ks) ? ~a : a;
      ack[sel] = (!tmo && k == w + 1 + d);
      if (sel == 1) drd1 = ack[1] ? rd : $urandom;
      else drd0 = ack[0] ? rd : $urandom;
      @(negedge clk);
      exp_req = (k >= w + 1) && (k < w + 1 + n_req);
      if (clr_hold) exp_err[o] = 1'b0;
      if (k == k_rdy && tmo) exp_err[sel] = 1'b1;
      else if (clr_hold) exp_err[sel] = 1'b0;
      exp_rd = (k == k_rdy) ? exp_q.pop_front() : 32'h0;
      n_checks++;
      if (req[sel] !== exp_req) begin
        n_fail++;
        $display("FAIL dev_req sel=%0d k=%0d got %b exp %b", sel, k, req[sel], exp_req);
      end
      n_checks++;
      if (rdy_[sel] !== (k != k_rdy)) begin
        n_fail++;
        $display("FAIL bus_rdy_ sel=%0d k=%0d got %b exp %b", sel, k, rdy_[sel], k != k_rdy);
      end
      n_checks++;
      if ((sel == 1 ? brd1 : brd0) !== exp_rd) begin
        n_fail++;
        $display("FAIL bus_rd_data sel=%0d k=%0d got %h exp %h", sel, k, sel == 1 ? brd1 : brd0, exp_rd);
      end
      n_checks++;
      if (errv !== exp_err) begin
        n_fail++;
        $display("FAIL err k=%0d got %b exp %b", k, errv, exp_err);
      end
      n_checks++;
      if (req[o] !== 1'b0 || rdy_[o] !== 1'b1) begin
        n_fail++;
        $display("FAIL unselected sel=%0d k=%0d req=%b rdy_=%b exp 0/1", o, k, req[o], rdy_[o]);
      end
      if (exp_req) begin
        n_checks++;
        if ((sel == 1 ? daddr1 : daddr0) !== a || drw[sel] !== r || (sel == 1 ? dwd1 : dwd0) !== wd) begin
          n_fail++;
          $display("FAIL dev_fields sel=%0d k=%0d addr=%h rw=%b wd=%h exp %h/%b/%h", sel, k,
                   sel == 1 ? daddr1 : daddr0, drw[sel], sel == 1 ? dwd1 : dwd0, a, r, wd);
        end
      end
    end
    as_ = 1'b1; cs_ = 2'b11; ack = 2'b00; addr = a; err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      as_ = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req !== 2'b00 || rdy_ !== 2'b11 || brd0 !== 32'h0 || brd1 !== 32'h0 || errv !== exp_err) begin
        n_fail++;
        $display("FAIL idle req=%b rdy_=%b rd0=%h rd1=%h err=%b exp 00/11/0/0/%b", req, rdy_, brd0, brd1, errv, exp_err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_ = 2'b11; as_ = 1'b1; rw = 1'b0; addr = '0; wdata = '0;
    ack = 2'b00; drd0 = '0; drd1 = '0; err_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (rdy_ !== 2'b11 || req !== 2'b00 || drw !== 2'b11 || errv !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl rdy_=%b req=%b rw=%b err=%b exp 11/00/11/00", rdy_, req, drw, errv);
    end
    n_checks++;
    if (brd0 !== 32'h0 || brd1 !== 32'h0 || daddr0 !== 30'h0 || daddr1 !== 30'h0 ||
        dwd0 !== 32'h0 || dwd1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data rd=%h/%h addr=%h/%h wd=%h/%h exp all 0", brd0, brd1, daddr0, daddr1, dwd0, dwd1);
    end
    @(negedge clk); rst = 1'b1;
    idle(2);
  endtask

  task automatic test_read_w0();
    access(0, 1'b1, 30'h10, 32'h5555_AAAA, 32'hCAFE_0001, 0, 0);
    idle(1);
  endtask

  task automatic test_write_w3();
    access(1, 1'b0, 30'h2A5, 32'h1234_5678, 32'hFFFF_0000, 2, 0);
    idle(1);
  endtask

  task automatic test_cs_ignore();
    @(posedge clk); #1;
    as_ = 1'b0; cs_ = 2'b11; rw = 1'b1; addr = 30'h33;
    idle(4);
  endtask

  task automatic test_as_in_req();
    access(0, 1'b1, 30'h40, 32'h0, 32'h0BAD_F00D, 3, 2);
    idle(3);
    access(1, 1'b1, 30'h41, 32'h0, 32'h600D_0001, 1, 2);
    idle(3);
  endtask

  task automatic test_timeout();
    access(0, 1'b1, 30'h50, 32'h0, 32'hDEAD_BEEF, -1, 0);
    idle(1);
    access(0, 1'b1, 30'h51, 32'h0, 32'h0000_0051, 1, 0);
    idle(1);
    access(0, 1'b1, 30'h52, 32'h0, 32'h0000_0052, 7, 0);
    idle(1);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    exp_err = 2'b00;
    @(negedge clk);
    n_checks++;
    if (errv !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clr got %b exp 00", errv);
    end
    clr_hold = 1'b1;
    access(0, 1'b0, 30'h53, 32'h7777_0000, 32'h0, -1, 0);
    clr_hold = 1'b0;
    idle(1);
    access(1, 1'b1, 30'h54, 32'h0, 32'hA5A5_5A5A, 20, 0);
    idle(1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    as_ = 1'b0; cs_ = 2'b10; rw = 1'b1; addr = 30'h60;
    @(posedge clk); #1;
    as_ = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_req got %b exp 1", req[0]);
    end
    #1 rst = 1'b0;
    #1;
    exp_err = 2'b00;
    n_checks++;
    if (req[0] !== 1'b0 || rdy_ !== 2'b11) begin
      n_fail++;
      $display("FAIL async_reset req=%b rdy_=%b exp 0/11", req[0], rdy_);
    end
    cs_ = 2'b11;
    @(negedge clk); rst = 1'b1;
    idle(2);
    access(0, 1'b1, 30'h61, 32'h0, 32'h0000_0061, 0, 0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    access(0, 1'b1, 30'h70, 32'h0, 32'h1111_0070, 0, 0);
    access(0, 1'b1, 30'h71, 32'h0, 32'h2222_0071, 0, 0);
    idle(1);
  endtask

  task automatic test_random();
    int sel, d;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 1);
      d = (sel == 1) ? $urandom_range(0, 6) : $urandom_range(0, 10);
      clr_hold = ($urandom_range(0, 3) == 0);
      access(sel, 1'($urandom_range(0, 1)), 30'($urandom), $urandom, $urandom, d,
             $urandom_range(0, 3));
      clr_hold = 1'b0;
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_read_w0();
    test_write_w3();
    test_cs_ignore();
    test_as_in_req();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_if.md
Name: bus_slave_if

Overview:
- Responder end of the shared system bus. A bus master drives req_/grnt_ arbitration, then a one-cycle as_ strobe, with addr/rw/wr_data held until it sees rdy_.
- This block sits in front of each bus slave (ROM, UART, GPIO, timer). It accepts an access when its chip select is active, applies programmable wait states, and runs a req/ack handshake to the local device.
- It returns a single-cycle rdy_ pulse with read data, and ends a transaction with an error on device timeout.

Parameters:
ADDR_W, 30, word-address width.
DATA_W, 32, data width.
WAIT_CYCLES, 0, idle cycles inserted between access latch and dev_req (0..15).
TIMEOUT, 255, maximum REQ cycles without dev_ack before error completion; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
bus_cs_  in  1  chip select from address decoder, active-low
bus_as_  in  1  address strobe, active-low, one cycle per access
bus_rw  in  1  1 = read, 0 = write
bus_addr  in  ADDR_W  word address
bus_wr_data  in  DATA_W  write data
bus_rd_data  out  DATA_W  read data; valid only while bus_rdy_=0, otherwise 0
bus_rdy_  out  1  ready, active-low, one-cycle pulse
dev_req  out  1  device request, held until ack
dev_rw  out  1  latched rw
dev_addr  out  ADDR_W  latched address
dev_wr_data  out  DATA_W  latched write data
dev_rd_data  in  DATA_W  device read data, sampled with dev_ack
dev_ack  in  1  device acknowledge, active-high
err_clr  in  1  clears the err flag
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state=IDLE; bus_rdy_=1; bus_rd_data=0; dev_req=0; dev_rw=1; dev_addr=0; dev_wr_data=0; err=0; counters=0. A reset mid-transaction drops dev_req immediately and sends no rdy_.
- All outputs are registered.
- States are IDLE, WAIT, REQ and RDY.
- IDLE:
  - Accept when bus_as_=0 and bus_cs_=0 in the same cycle. Latch bus_addr/bus_rw/bus_wr_data into dev_addr/dev_rw/dev_wr_data.
  - If WAIT_CYCLES=0, go to REQ with dev_req<=1. Otherwise load wait_cnt=WAIT_CYCLES and go to WAIT.
  - bus_as_=0 with bus_cs_=1 is ignored.
- WAIT: decrement wait_cnt each cycle. When wait_cnt=1, go to REQ and set dev_req<=1. Exactly WAIT_CYCLES cycles are spent in WAIT.
- REQ:
  - dev_req=1 and dev_* stable for every REQ cycle. to_cnt increments each cycle.
  - Normal completion: dev_ack=1 is sampled. bus_rd_data<= dev_rd_data if dev_rw=1, else 0. Then dev_req<=0, bus_rdy_<=0, to_cnt<=0, go to RDY.
  - Timeout: TIMEOUT!=0, to_cnt reaches TIMEOUT-1, and there is no ack. Then bus_rd_data<=0, err<=1, dev_req<=0, bus_rdy_<=0, go to RDY.
  - An ack in the same cycle as the timeout counts as a normal completion.
- RDY: bus_rdy_=0 for exactly this one cycle. Next cycle: bus_rdy_<=1, bus_rd_data<=0, state=IDLE.
- bus_as_ outside IDLE is ignored. There is no queuing; one access is in flight at a time.
- Latency: as_ is sampled at edge T.
  - dev_req is high from T+1+WAIT_CYCLES.
  - If the ack is seen on the first REQ cycle, bus_rdy_=0 in cycle T+2+WAIT_CYCLES.
  - Each extra ack-delay cycle adds one cycle.
- Back-to-back: a new as_ may be accepted in the cycle after RDY, which is the first IDLE cycle.
- err: set on timeout, cleared by err_clr=1. If set and clear occur in the same cycle, set wins.
- bus_rd_data is 0 whenever bus_rdy_=1, so slave outputs can be OR-combined on the bus.
- dev_* outputs keep their last latched values in IDLE.

Test Plan:
- Read, WAIT_CYCLES=0: as_=0, cs_=0, rw=1, addr=30'h10; device acks in the first REQ cycle with 32'hCAFE_0001 -> dev_req high 1 cycle; bus_rdy_=0 at T+2 with bus_rd_data=32'hCAFE_0001; bus_rd_data=0 the cycle after.
- Write, WAIT_CYCLES=3, ack delayed 2 cycles: wr_data=32'h1234_5678 -> dev_req rises at T+4 with dev_wr_data=32'h1234_5678, dev_rw=0; bus_rdy_=0 at T+7 with bus_rd_data=0.
- as_=0 with cs_=1 -> no dev_req and no rdy_. A second as_ while in REQ is ignored; exactly one rdy_ pulse for the first access.
- TIMEOUT=8, no ack -> dev_req high 8 cycles; rdy_ pulse with rd_data=0; err=1 and stays 1 across the next good access; err_clr=1 -> err=0.
- rst=0 asserted while in REQ -> dev_req=0 in the same cycle with no clock edge. After release, state is IDLE and the next access completes normally.
- Back-to-back reads: second as_ in the first IDLE cycle after RDY -> two rdy_ pulses 3 cycles apart (WAIT_CYCLES=0, immediate ack).
